// File: rtl/bbus_pkg.sv
// rtl/bbus_pkg.sv - shared types and limits for the buffered device bus arbiter
package bbus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    typedef logic gnt_t;

    localparam gnt_t GNT_W = 1'b0;
    localparam gnt_t GNT_S = 1'b1;

    localparam int T_MIN = 1;
    localparam int T_MAX = 15;
    localparam int CNT_W = 4;

endpackage

// File: rtl/bbus_phase_timer.sv
// rtl/bbus_phase_timer.sv - loadable down-counter that flags the last cycle of a bus phase
module bbus_phase_timer
    import bbus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bbus_arbiter.sv
// rtl/bbus_arbiter.sv - W5300/SL811 bus sharing with SETUP/STROBE/HOLD sequencing
// Optional BBUS_ARB_RR_EN selects round-robin tie-breaking instead of SL811 fixed priority.
module bbus_arbiter
    import bbus_pkg::*;
#(
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 3,
    parameter int T_HOLD   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       w_req,
    input  logic       w_rnw,
    input  logic [9:0] w_addr,
    input  logic [7:0] w_wdata,
    output logic       w_ack,
    input  logic       s_req,
    input  logic       s_rnw,
    input  logic       s_a0,
    input  logic [7:0] s_wdata,
    output logic       s_ack,
    output logic [7:0] rdata,
    output logic       w5300_cs_n,
    output logic [9:0] w5300_addr,
    output logic       sl811_cs_n,
    output logic       sl811_a0,
    output logic       brd_n,
    output logic       bwr_n,
    input  logic [7:0] bd_in,
    output logic [7:0] bd_out,
    output logic       bd_oe
);

    generate
        if (T_SETUP < T_MIN || T_SETUP > T_MAX) begin : g_bad_setup
            $error("bbus_arbiter: T_SETUP must be within 1..15");
        end
        if (T_STROBE < T_MIN || T_STROBE > T_MAX) begin : g_bad_strobe
            $error("bbus_arbiter: T_STROBE must be within 1..15");
        end
        if (T_HOLD < T_MIN || T_HOLD > T_MAX) begin : g_bad_hold
            $error("bbus_arbiter: T_HOLD must be within 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(T_STROBE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(T_HOLD - 1);

    state_t           r_state;
    state_t           w_nxt_state;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_zero;
    gnt_t             r_gnt;
    gnt_t             w_gnt_new;
    gnt_t             w_gnt;
    logic             r_rnw;
    logic             w_cur_rnw;
    logic             w_accept;
    logic             w_busy_nxt;

    bbus_phase_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

`ifdef BBUS_ARB_RR_EN
    gnt_t r_last;

    always_comb begin
        w_gnt_new = s_req ? GNT_S : GNT_W;
        if (w_req && s_req) begin
            w_gnt_new = (r_last == GNT_S) ? GNT_W : GNT_S;
        end
    end

    // Starts as SL811 so the first tie after reset goes to the W5300.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= GNT_S;
        end else if (w_accept) begin
            r_last <= w_gnt_new;
        end
    end
`else
    assign w_gnt_new = s_req ? GNT_S : GNT_W;
`endif

    assign w_accept  = (r_state == IDLE) && (w_req || s_req);
    assign w_gnt     = w_accept ? w_gnt_new : r_gnt;
    assign w_cur_rnw = w_accept ? ((w_gnt_new == GNT_S) ? s_rnw : w_rnw) : r_rnw;

    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        case (r_state)
            IDLE: begin
                if (w_req || s_req) begin
                    w_nxt_state = SETUP;
                    w_load      = 1'b1;
                    w_load_val  = LD_SETUP;
                end
            end
            SETUP: begin
                if (w_zero) begin
                    w_nxt_state = STROBE;
                    w_load      = 1'b1;
                    w_load_val  = LD_STROBE;
                end
            end
            STROBE: begin
                if (w_zero) begin
                    w_nxt_state = HOLD;
                    w_load      = 1'b1;
                    w_load_val  = LD_HOLD;
                end
            end
            HOLD: begin
                if (w_zero) begin
                    w_nxt_state = DONE;
                end
            end
            DONE:    w_nxt_state = IDLE;
            default: w_nxt_state = IDLE;
        endcase
    end

    assign w_busy_nxt = (w_nxt_state == SETUP) || (w_nxt_state == STROBE) ||
                        (w_nxt_state == HOLD);

    // Pin outputs are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= GNT_W;
            r_rnw      <= 1'b0;
            w5300_cs_n <= 1'b1;
            sl811_cs_n <= 1'b1;
            brd_n      <= 1'b1;
            bwr_n      <= 1'b1;
            bd_oe      <= 1'b0;
            bd_out     <= '0;
            w5300_addr <= '0;
            sl811_a0   <= 1'b0;
            w_ack      <= 1'b0;
            s_ack      <= 1'b0;
            rdata      <= '0;
        end else begin
            r_state <= w_nxt_state;
            if (w_accept) begin
                r_gnt <= w_gnt_new;
                r_rnw <= w_cur_rnw;
                if (w_gnt_new == GNT_S) begin
                    sl811_a0 <= s_a0;
                end else begin
                    w5300_addr <= w_addr;
                end
                if (!w_cur_rnw) begin
                    bd_out <= (w_gnt_new == GNT_S) ? s_wdata : w_wdata;
                end
            end
            w5300_cs_n <= !(w_busy_nxt && (w_gnt == GNT_W));
            sl811_cs_n <= !(w_busy_nxt && (w_gnt == GNT_S));
            brd_n      <= !((w_nxt_state == STROBE) && w_cur_rnw);
            bwr_n      <= !((w_nxt_state == STROBE) && !w_cur_rnw);
            bd_oe      <= w_busy_nxt && !w_cur_rnw;
            w_ack      <= (w_nxt_state == DONE) && (w_gnt == GNT_W);
            s_ack      <= (w_nxt_state == DONE) && (w_gnt == GNT_S);
            if ((r_state == STROBE) && w_zero && r_rnw) begin
                rdata <= bd_in;
            end
        end
    end

endmodule

// File: tb/tb_bbus_arbiter.sv
// tb/tb_bbus_arbiter.sv - self-checking bench for bbus_arbiter with an offset-based bus model
module tb_bbus_arbiter;

    localparam int TS  = 1;
    localparam int TST = 3;
    localparam int TH  = 1;
    localparam int SUM = TS + TST + TH;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_req, w_rnw, s_req, s_rnw, s_a0;
    logic [9:0] w_addr;
    logic [7:0] w_wdata, s_wdata, bd_in;
    logic       w_ack, s_ack, w5300_cs_n, sl811_cs_n, sl811_a0, brd_n, bwr_n, bd_oe;
    logic [7:0] rdata, bd_out;
    logic [9:0] w5300_addr;

    logic       x_w_req, s6_req;
    logic       x_w_ack, x_s_ack, x_w5300_cs_n, x_sl811_cs_n, x_sl811_a0, x_brd_n, x_bwr_n, x_bd_oe;
    logic [7:0] x_rdata, x_bd_out;
    logic [9:0] x_w5300_addr;

    always #5 clk = ~clk;

    bbus_arbiter #(.T_SETUP(TS), .T_STROBE(TST), .T_HOLD(TH)) dut (
        .clk(clk), .rst(rst),
        .w_req(w_req), .w_rnw(w_rnw), .w_addr(w_addr), .w_wdata(w_wdata), .w_ack(w_ack),
        .s_req(s_req), .s_rnw(s_rnw), .s_a0(s_a0), .s_wdata(s_wdata), .s_ack(s_ack),
        .rdata(rdata), .w5300_cs_n(w5300_cs_n), .w5300_addr(w5300_addr),
        .sl811_cs_n(sl811_cs_n), .sl811_a0(sl811_a0), .brd_n(brd_n), .bwr_n(bwr_n),
        .bd_in(bd_in), .bd_out(bd_out), .bd_oe(bd_oe)
    );

    bbus_arbiter #(.T_SETUP(2), .T_STROBE(1), .T_HOLD(3)) dut6 (
        .clk(clk), .rst(rst),
        .w_req(x_w_req), .w_rnw(w_rnw), .w_addr(w_addr), .w_wdata(w_wdata), .w_ack(x_w_ack),
        .s_req(s6_req), .s_rnw(s_rnw), .s_a0(s_a0), .s_wdata(s_wdata), .s_ack(x_s_ack),
        .rdata(x_rdata), .w5300_cs_n(x_w5300_cs_n), .w5300_addr(x_w5300_addr),
        .sl811_cs_n(x_sl811_cs_n), .sl811_a0(x_sl811_a0), .brd_n(x_brd_n), .bwr_n(x_bwr_n),
        .bd_in(bd_in), .bd_out(x_bd_out), .bd_oe(x_bd_oe)
    );

    int n_vec = 0;
    int n_err = 0;
    int k = 0;

    // Reference model: an access granted at edge a owns the bus for edges a..a+SUM-1,
    // strobes during offsets TS..TS+TST-1, acks at offset SUM, and the next grant is possible at a+SUM+2.
    bit         m_busy = 0;
    int         m_a = 0;
    int         m_next_free = 0;
    bit         m_gnt = 0;
    bit         m_rnw = 0;
    bit         m_last = 1;
    logic       e_wcs, e_scs, e_brd, e_bwr, e_oe, e_wack, e_sack, e_a0;
    logic [7:0] e_rdata, e_bdout;
    logic [9:0] e_addr;

    task automatic step();
        int off;
        @(posedge clk);
        k++;
        if (rst) begin
            m_busy = 0; m_next_free = k + 1; m_last = 1;
            e_rdata = '0; e_bdout = '0; e_addr = '0; e_a0 = 1'b0;
            e_wcs = 1; e_scs = 1; e_brd = 1; e_bwr = 1; e_oe = 0; e_wack = 0; e_sack = 0;
        end else begin
            if (!m_busy && k >= m_next_free && (w_req || s_req)) begin
`ifdef BBUS_ARB_RR_EN
                if (w_req && s_req) m_gnt = ~m_last;
                else                m_gnt = s_req;
`else
                m_gnt = s_req;
`endif
                m_last = m_gnt; m_busy = 1; m_a = k;
                if (m_gnt) begin
                    m_rnw = s_rnw; e_a0 = s_a0;
                    if (!s_rnw) e_bdout = s_wdata;
                end else begin
                    m_rnw = w_rnw; e_addr = w_addr;
                    if (!w_rnw) e_bdout = w_wdata;
                end
            end
            e_wcs = 1; e_scs = 1; e_brd = 1; e_bwr = 1; e_oe = 0; e_wack = 0; e_sack = 0;
            if (m_busy) begin
                off = k - m_a;
                if (off < SUM) begin
                    if (m_gnt) e_scs = 0; else e_wcs = 0;
                    e_oe = !m_rnw;
                end
                if (off >= TS && off < TS + TST) begin
                    if (m_rnw) e_brd = 0; else e_bwr = 0;
                end
                if (off == TS + TST && m_rnw) e_rdata = bd_in;
                if (off == SUM) begin
                    if (m_gnt) e_sack = 1; else e_wack = 1;
                    m_busy = 0; m_next_free = k + 2;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1; idle(2);
        n_vec++;
        if ({w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, w_ack, s_ack} !== 7'b1111000) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 1111000",
                     {w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, w_ack, s_ack});
        end
        n_vec++;
        if ({rdata, w5300_addr, sl811_a0, bd_out} !== 27'd0) begin
            n_err++;
            $display("FAIL reset_data got %h want 0", {rdata, w5300_addr, sl811_a0, bd_out});
        end
        n_vec++;
        if ({x_w5300_cs_n, x_sl811_cs_n, x_brd_n, x_bwr_n, x_bd_oe, x_s_ack} !== 6'b111100) begin
            n_err++;
            $display("FAIL reset_dut6 got %b want 111100",
                     {x_w5300_cs_n, x_sl811_cs_n, x_brd_n, x_bwr_n, x_bd_oe, x_s_ack});
        end
        rst = 0; idle(2);
    endtask

    // Ack lands in cycle 2+SUM counting the request cycle as cycle 1, i.e. SUM+1 edges later.
    task automatic test_w_write();
        int cs_cnt = 0, wr_cnt = 0, rd_cnt = 0, bad = 0, ack_at = -1, acks = 0;
        w_req = 1; w_rnw = 0; w_addr = 10'h2AB; w_wdata = 8'h5A;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (!w5300_cs_n) cs_cnt++;
            if (!brd_n) rd_cnt++;
            if (!bwr_n) begin
                wr_cnt++;
                if (bd_out !== 8'h5A || bd_oe !== 1'b1 || w5300_addr !== 10'h2AB) bad++;
            end
            if (w_ack) begin
                acks++;
                if (ack_at < 0) ack_at = n;
                w_req = 0;
            end
        end
        n_vec++; if (cs_cnt !== SUM) begin n_err++; $display("FAIL wr_cs_width got %0d want %0d", cs_cnt, SUM); end
        n_vec++; if (wr_cnt !== TST) begin n_err++; $display("FAIL wr_strobe_width got %0d want %0d", wr_cnt, TST); end
        n_vec++; if (rd_cnt !== 0) begin n_err++; $display("FAIL wr_no_brd got %0d want 0", rd_cnt); end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL wr_data_during_strobe got %0d bad want 0", bad); end
        n_vec++; if (ack_at !== SUM + 1) begin n_err++; $display("FAIL wr_ack_latency got %0d want %0d", ack_at, SUM + 1); end
        n_vec++; if (acks !== 1) begin n_err++; $display("FAIL wr_ack_count got %0d want 1", acks); end
        idle(3);
    endtask

    task automatic test_s_read();
        int cs_cnt = 0, rd_cnt = 0, wr_cnt = 0, oe_cnt = 0, a0_bad = 0, ack_at = -1;
        logic [7:0] rd_at_ack = 8'h00;
        s_req = 1; s_rnw = 1; s_a0 = 1; s_wdata = 8'hEE;
        for (int n = 1; n <= 12; n++) begin
            bd_in = (n >= TS + 2 && n <= TS + TST + 1) ? 8'hC3 : 8'h3C;
            step();
            if (!sl811_cs_n) begin cs_cnt++; if (sl811_a0 !== 1'b1) a0_bad++; end
            if (!brd_n) rd_cnt++;
            if (!bwr_n) wr_cnt++;
            if (bd_oe) oe_cnt++;
            if (s_ack) begin
                if (ack_at < 0) begin ack_at = n; rd_at_ack = rdata; end
                s_req = 0;
            end
        end
        n_vec++; if (cs_cnt !== SUM) begin n_err++; $display("FAIL rd_cs_width got %0d want %0d", cs_cnt, SUM); end
        n_vec++; if (rd_cnt !== TST) begin n_err++; $display("FAIL rd_strobe_width got %0d want %0d", rd_cnt, TST); end
        n_vec++; if (wr_cnt !== 0 || oe_cnt !== 0) begin n_err++; $display("FAIL rd_no_drive got bwr=%0d oe=%0d want 0,0", wr_cnt, oe_cnt); end
        n_vec++; if (a0_bad !== 0) begin n_err++; $display("FAIL rd_a0 got %0d bad want 0", a0_bad); end
        n_vec++; if (ack_at !== SUM + 1) begin n_err++; $display("FAIL rd_ack_latency got %0d want %0d", ack_at, SUM + 1); end
        n_vec++; if (rd_at_ack !== 8'hC3) begin n_err++; $display("FAIL rd_capture got %h want c3", rd_at_ack); end
        idle(3);
    endtask

    task automatic test_tie();
        int first = -1, second = -1, win;
        int exp_first;
`ifdef BBUS_ARB_RR_EN
        exp_first = 0;
`else
        exp_first = 1;
`endif
        w_req = 1; s_req = 1; w_rnw = 0; s_rnw = 0;
        w_wdata = 8'h11; s_wdata = 8'h22; w_addr = 10'h015; s_a0 = 0;
        for (int n = 0; n < 40 && second < 0; n++) begin
            step();
            if (w_ack) begin if (first < 0) first = 0; else second = 0; w_req = 0; end
            if (s_ack) begin if (first < 0) first = 1; else second = 1; s_req = 0; end
        end
        w_req = 0; s_req = 0;
        n_vec++; if (first !== exp_first) begin n_err++; $display("FAIL tie_first got %0d want %0d (0=W 1=S)", first, exp_first); end
        n_vec++; if (second !== 1 - exp_first) begin n_err++; $display("FAIL tie_second got %0d want %0d", second, 1 - exp_first); end
        idle(3);
        for (int t = 0; t < 4; t++) begin
            int exp_win;
`ifdef BBUS_ARB_RR_EN
            exp_win = t % 2;
`else
            exp_win = 1;
`endif
            w_req = 1; s_req = 1; win = -1;
            for (int n = 0; n < 20 && win < 0; n++) begin
                step();
                if (w_ack) win = 0;
                else if (s_ack) win = 1;
            end
            w_req = 0; s_req = 0;
            n_vec++; if (win !== exp_win) begin n_err++; $display("FAIL tie_repeat%0d got %0d want %0d", t, win, exp_win); end
            idle(3);
        end
    endtask

    task automatic test_starve();
        int w_cnt = 0, s_cnt = 0, ew_cnt = 0, es_cnt = 0, viol = 0;
        w_req = 1; s_req = 1; w_rnw = 0; s_rnw = 1; w_addr = 10'h100; w_wdata = 8'h99; s_a0 = 0;
        for (int n = 0; n < 60; n++) begin
            bd_in = 8'($urandom);
            step();
            if (w_ack) w_cnt++;
            if (s_ack) s_cnt++;
            if (e_wack) ew_cnt++;
            if (e_sack) es_cnt++;
            if ((!w5300_cs_n && !sl811_cs_n) || (!brd_n && !bwr_n) ||
                ((!brd_n || !bwr_n) && w5300_cs_n && sl811_cs_n)) viol++;
        end
        w_req = 0; s_req = 0;
        idle(SUM + 3);
        n_vec++; if (viol !== 0) begin n_err++; $display("FAIL starve_invariants got %0d violations want 0", viol); end
        n_vec++; if (w_cnt !== ew_cnt || s_cnt !== es_cnt) begin n_err++; $display("FAIL starve_acks got w=%0d s=%0d want w=%0d s=%0d", w_cnt, s_cnt, ew_cnt, es_cnt); end
`ifdef BBUS_ARB_RR_EN
        n_vec++; if (w_cnt - s_cnt > 1 || s_cnt - w_cnt > 1) begin n_err++; $display("FAIL starve_rr_balance got w=%0d s=%0d want within 1", w_cnt, s_cnt); end
`else
        n_vec++; if (w_cnt !== 0) begin n_err++; $display("FAIL starve_w_granted got %0d want 0", w_cnt); end
`endif
    endtask

    task automatic test_rst_mid();
        int ack_at = -1, acks = 0;
        w_req = 1; w_rnw = 0; w_addr = 10'h3C1; w_wdata = 8'hA5;
        idle(2);
        n_vec++; if (bwr_n !== 1'b0) begin n_err++; $display("FAIL rst_mid_in_strobe got bwr_n=%b want 0", bwr_n); end
        rst = 1; step();
        n_vec++;
        if ({w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, w_ack} !== 6'b111100) begin
            n_err++;
            $display("FAIL rst_mid_outputs got %b want 111100",
                     {w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, w_ack});
        end
        rst = 0; step();
        n_vec++; if (w5300_cs_n !== 1'b0) begin n_err++; $display("FAIL rst_mid_regrant got cs_n=%b want 0", w5300_cs_n); end
        for (int n = 1; n <= 12; n++) begin
            step();
            if (w_ack) begin acks++; if (ack_at < 0) ack_at = n; w_req = 0; end
        end
        n_vec++; if (ack_at !== SUM || acks !== 1) begin n_err++; $display("FAIL rst_mid_ack got at=%0d cnt=%0d want at=%0d cnt=1", ack_at, acks, SUM); end
        idle(2);
    endtask

    task automatic test_timing6();
        int cs_cnt = 0, wr_cnt = 0, ack_at = -1, bad = 0;
        s6_req = 1; s_rnw = 0; s_a0 = 0; s_wdata = 8'h77;
        for (int n = 1; n <= 14; n++) begin
            step();
            if (!x_sl811_cs_n) cs_cnt++;
            if (!x_bwr_n) begin wr_cnt++; if (x_bd_out !== 8'h77 || x_bd_oe !== 1'b1) bad++; end
            if (x_s_ack) begin if (ack_at < 0) ack_at = n; s6_req = 0; end
        end
        n_vec++; if (cs_cnt !== 6) begin n_err++; $display("FAIL t6_cs_width got %0d want 6", cs_cnt); end
        n_vec++; if (wr_cnt !== 1 || bad !== 0) begin n_err++; $display("FAIL t6_strobe got width=%0d bad=%0d want 1,0", wr_cnt, bad); end
        n_vec++; if (ack_at !== 7) begin n_err++; $display("FAIL t6_ack_latency got %0d want 7", ack_at); end
    endtask

    task automatic test_random();
        bit w_pend = 0, s_pend = 0;
        int viol = 0;
        for (int i = 0; i < 460; i++) begin
            if (!w_pend) begin
                if (i < 400 && $urandom_range(0, 2) == 0) begin
                    w_req = 1; w_rnw = 1'($urandom); w_addr = 10'($urandom); w_wdata = 8'($urandom);
                    w_pend = 1;
                end else w_req = 0;
            end
            if (!s_pend) begin
                if (i < 400 && $urandom_range(0, 2) == 0) begin
                    s_req = 1; s_rnw = 1'($urandom); s_a0 = 1'($urandom); s_wdata = 8'($urandom);
                    s_pend = 1;
                end else s_req = 0;
            end
            bd_in = 8'($urandom);
            step();
            n_vec++;
            if ({w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, w_ack, s_ack, rdata, w5300_addr, sl811_a0, bd_out} !==
                {e_wcs, e_scs, e_brd, e_bwr, e_oe, e_wack, e_sack, e_rdata, e_addr, e_a0, e_bdout}) begin
                n_err++;
                $display("FAIL random_cycle%0d got %h want %h", i,
                    {w5300_cs_n, sl811_cs_n, brd_n, bwr_n, bd_oe, w_ack, s_ack, rdata, w5300_addr, sl811_a0, bd_out},
                    {e_wcs, e_scs, e_brd, e_bwr, e_oe, e_wack, e_sack, e_rdata, e_addr, e_a0, e_bdout});
            end
            if ((!w5300_cs_n && !sl811_cs_n) || (!brd_n && !bwr_n) ||
                ((!brd_n || !bwr_n) && w5300_cs_n && sl811_cs_n)) viol++;
            if (e_wack) w_pend = 0;
            if (e_sack) s_pend = 0;
        end
        w_req = 0; s_req = 0;
        n_vec++; if (viol !== 0) begin n_err++; $display("FAIL random_invariants got %0d violations want 0", viol); end
        n_vec++; if (w_pend || s_pend) begin n_err++; $display("FAIL random_drain got pending w=%0d s=%0d want 0,0", w_pend, s_pend); end
        idle(3);
    endtask

    initial begin
        rst = 1; w_req = 0; w_rnw = 0; w_addr = '0; w_wdata = '0;
        s_req = 0; s_rnw = 0; s_a0 = 0; s_wdata = '0; bd_in = '0;
        x_w_req = 0; s6_req = 0;
        e_wcs = 1; e_scs = 1; e_brd = 1; e_bwr = 1; e_oe = 0; e_wack = 0; e_sack = 0;
        e_rdata = '0; e_bdout = '0; e_addr = '0; e_a0 = 0;
        @(negedge clk);
        test_reset();
        test_w_write();
        test_s_read();
        test_tie();
        test_starve();
        test_rst_mid();
        test_timing6();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at vectors=%0d want completion", n_vec);
        $fatal(1);
    end

endmodule
